// File: rtl/ssd_display_driver.sv
// ssd_display_driver
// Converts a 13-bit binary value to four BCD digits with a sequential
// shift-and-add-3 FSM (IDLE -> CONV x13 -> LOAD, 15 cycles per loop), then
// time-multiplexes the digits onto an active-low 4-digit seven-segment display.
// Optional feature macro: SSD_LEADING_ZERO_BLANK_EN blanks leading-zero digits
// (the units digit is always shown).
module ssd_display_driver #(
    parameter int REFRESH_BITS = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] value,
    output logic [3:0]  anode,
    output logic [6:0]  segments,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t                  state_reg;
    logic [12:0]             shift_reg;
    logic [15:0]             bcd_reg;
    logic [3:0]              step_reg;
    logic [15:0]             display_reg;
    logic [REFRESH_BITS-1:0] scan_reg;

    logic [14:0] bcd_adj;
    logic [1:0]  digit_idx;
    logic [3:0]  digit_val;
    logic        digit_blank;

    // Add-3 correction on the units, tens and hundreds nibbles.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate
    // The thousands nibble of a 13-bit input is at most 4 before any shift
    // (8191 ends as 8), so it never needs correcting and its top bit is
    // always shifted out as zero.
    assign bcd_adj[14:12] = bcd_reg[14:12];

    // Conversion FSM: capture, 13 shift steps, then publish to the display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bcd_reg     <= '0;
            step_reg    <= '0;
            display_reg <= '0;
            busy        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    shift_reg <= value;
                    bcd_reg   <= '0;
                    step_reg  <= '0;
                    busy      <= 1'b1;
                    state_reg <= CONV;
                end
                CONV: begin
                    {bcd_reg, shift_reg} <= {bcd_adj, shift_reg, 1'b0};
                    step_reg <= step_reg + 4'd1;
                    if (step_reg == 4'd12) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    display_reg <= bcd_reg;
                    busy        <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Free-running scan counter; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_reg <= '0;
        end else begin
            scan_reg <= scan_reg + 1'b1;
        end
    end

    assign digit_idx = scan_reg[REFRESH_BITS-1 -: 2];
    assign digit_val = display_reg[{digit_idx, 2'b00} +: 4];

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [1:0] msd_idx;

    // Position of the most significant nonzero digit (units if all zero).
    always_comb begin
        msd_idx = 2'd0;
        if (display_reg[7:4]   != 4'd0) msd_idx = 2'd1;
        if (display_reg[11:8]  != 4'd0) msd_idx = 2'd2;
        if (display_reg[15:12] != 4'd0) msd_idx = 2'd3;
    end
    assign digit_blank = (digit_idx > msd_idx);
`else
    assign digit_blank = 1'b0;
`endif

    // Active-low {a,b,c,d,e,f,g} pattern for one BCD nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Registered display drive from the current scan slot and display register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode    <= 4'b1111;
            segments <= 7'b1111111;
        end else if (digit_blank) begin
            anode    <= 4'b1111;
            segments <= 7'b1111111;
        end else begin
            anode    <= ~(4'b0001 << digit_idx);
            segments <= seg_decode(digit_val);
        end
    end

endmodule

// File: tb/tb_ssd_display_driver.sv
// Testbench for ssd_display_driver (REFRESH_BITS=4). A capture model pushes the
// value taken at each conversion start into a scoreboard queue; a negedge
// monitor pops it when busy falls and checks anode/segments/busy every cycle
// against digits computed with plain decimal arithmetic.
module tb_ssd_display_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] value = '0;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int e = 0;           // clock edges since reset release
    int loads = 0;
    int disp_model = 0;  // value currently held by the display
    logic prev_busy = 1'b0;
    int exp_q[$];
    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

    ssd_display_driver #(.REFRESH_BITS(4)) dut (
        .clk(clk), .reset(reset), .value(value),
        .anode(anode), .segments(segments), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Expected display drive for a displayed decimal number and scan slot.
    task automatic model_out(input int v, input int idx,
                             output logic [3:0] an, output logic [6:0] sg);
        int d[4];
        int msd;
        bit blank;
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = (v / 100) % 10;
        d[3] = v / 1000;
        msd = 0;
        for (int k = 1; k < 4; k++) if (d[k] != 0) msd = k;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        blank = (idx > msd);
`else
        blank = 1'b0;
`endif
        if (blank) begin
            an = 4'b1111;
            sg = 7'b1111111;
        end else begin
            an = 4'b1111;
            an[idx] = 1'b0;
            sg = seg_tab[d[idx]];
        end
    endtask

    // Capture model: a conversion starts every 15 edges after reset release.
    always @(posedge clk) begin
        if (reset) begin
            e = 0;
            exp_q.delete();
        end else begin
            e++;
            if ((e - 1) % 15 == 0) exp_q.push_back(int'(value));
        end
    end

    // Monitor: compare outputs each cycle, retire a conversion when busy falls.
    always @(negedge clk) begin
        logic [3:0] an_x;
        logic [6:0] sg_x;
        if (reset || e == 0) begin
            check("reset_anode", anode, 4'b1111);
            check("reset_segments", segments, 7'b1111111);
            check("reset_busy", busy, 0);
            if (reset) disp_model = 0;
            prev_busy = 1'b0;
        end else begin
            check("busy", busy, (e % 15 != 0) ? 1 : 0);
            model_out(disp_model, ((e - 1) % 16) / 4, an_x, sg_x);
            check("anode", anode, an_x);
            check("segments", segments, sg_x);
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("load_without_capture", 1, 0);
                end else begin
                    disp_model = exp_q.pop_front();
                    loads++;
                    $display("[TB] load #%0d: display now %0d", loads, disp_model);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        // Directed cases: typical value, maximum, mid-conversion change, small value, zero.
        value = 13'd1234; tick(40);
        value = 13'd8191; tick(35);
        value = 13'd5;    tick(20);
        value = 13'd9;    tick(35);
        value = 13'd7;    tick(35);
        value = 13'd0;    tick(35);
        // Reset pulsed during conversion step 8 of 1234.
        value = 13'd1234;
        tick(1);
        for (int k = 0; k < 30 && (e % 15) != 8; k++) tick(1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(35);
        // Random values held for random durations, including rapid changes.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0:       value = 13'd8191;
                1:       value = 13'($urandom_range(0, 99));
                default: value = 13'($urandom_range(0, 8191));
            endcase
            tick($urandom_range(1, 25));
        end
        tick(32);
        tests++;
        if (loads < 40) begin
            fails++;
            $display("FAIL load_count: got %0d expected at least 40", loads);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
